// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/forwarding controller for the 5-stage core: shadow scoreboard, stalls, flushes, drain.
// Optional perf counters (stall_cnt, flush_cnt) are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int RADDR_W      = 4,
    parameter int LOAD_LAT     = 1,
    parameter int BR_PENALTY   = 2,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic               id_rs_used,
    input  logic               id_rt_used,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_wr,
    input  logic               id_is_load,
    input  logic               id_is_hlt,
    input  logic               br_taken,
    input  logic               imem_busy,
    input  logic               dmem_busy,
    output logic               pc_we,
    output logic               ifid_we,
    output logic               ifid_flush,
    output logic               idex_bubble,
    output logic               pipe_freeze,
    output logic [1:0]         fwd_a_sel,
    output logic [1:0]         fwd_b_sel,
    output logic               hlt
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        flush_cnt
`endif
);

    // state   | meaning
    // S_RUN    | normal issue
    // S_LSTALL | extra load-use bubbles still owed (LOAD_LAT > 1)
    // S_DRAIN  | HLT left ID, counting advancing cycles before halting
    // S_HALTED | processor halted until reset
    typedef enum logic [1:0] {S_RUN, S_LSTALL, S_DRAIN, S_HALTED} state_t;

    typedef struct packed {
        logic               valid;
        logic [RADDR_W-1:0] rs;
        logic [RADDR_W-1:0] rt;
        logic [RADDR_W-1:0] rd;
        logic               wr;
        logic               load;
    } slot_t;

    localparam int CNT_W = 8;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    slot_t             ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_slot;
    logic              halted, load_use, lstall, br_act;
    logic              mem_fwd_ok, wb_fwd_ok;

    assign halted   = (state_q == S_HALTED);
    assign hlt      = halted;
    assign load_use = id_valid && ex_q.valid && ex_q.load && (ex_q.rd != '0) &&
                      ((id_rs_used && (id_rs == ex_q.rd)) || (id_rt_used && (id_rt == ex_q.rd)));
    assign br_act   = !dmem_busy && !halted && br_taken;
    assign lstall   = !dmem_busy && !halted && !br_taken &&
                      ((state_q == S_LSTALL) || ((state_q == S_RUN) && load_use));

    assign mem_fwd_ok = mem_q.valid && mem_q.wr && (mem_q.rd != '0);
    assign wb_fwd_ok  = wb_q.valid && wb_q.wr && (wb_q.rd != '0);

    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (ex_q.valid) begin
            if (mem_fwd_ok && (mem_q.rd == ex_q.rs))     fwd_a_sel = 2'b01;
            else if (wb_fwd_ok && (wb_q.rd == ex_q.rs))  fwd_a_sel = 2'b10;
            if (mem_fwd_ok && (mem_q.rd == ex_q.rt))     fwd_b_sel = 2'b01;
            else if (wb_fwd_ok && (wb_q.rd == ex_q.rt))  fwd_b_sel = 2'b10;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (dmem_busy) begin
            pipe_freeze = 1'b1;
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
        end else if (halted) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end else if (br_act) begin
            // a pending HLT or load-use was on the wrong path
            ifid_flush  = 1'b1;
            idex_bubble = (BR_PENALTY == 2);
            state_d     = S_RUN;
            cnt_d       = '0;
        end else if (lstall) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            if (state_q == S_LSTALL) begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = S_RUN;
            end else if (LOAD_LAT > 1) begin
                state_d = S_LSTALL;
                cnt_d   = CNT_W'(LOAD_LAT - 1);
            end
        end else begin
            if (imem_busy) begin
                pc_we      = 1'b0;
                ifid_flush = 1'b1;
            end
            if (state_q == S_DRAIN) begin
                pc_we      = 1'b0;
                ifid_flush = 1'b1;
                cnt_d      = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = S_HALTED;
            end else if (id_valid && id_is_hlt) begin
                pc_we      = 1'b0;
                ifid_flush = 1'b1;
                state_d    = S_DRAIN;
                cnt_d      = CNT_W'(DRAIN_CYCLES);
            end
        end
    end

    always_comb begin
        id_slot.valid = id_valid && !idex_bubble;
        id_slot.rs    = id_rs_used ? id_rs : '0;
        id_slot.rt    = id_rt_used ? id_rt : '0;
        id_slot.rd    = id_rd;
        id_slot.wr    = id_wr;
        id_slot.load  = id_is_load;
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!pipe_freeze) begin
            ex_d  = id_slot;
            mem_d = ex_q;
            wb_d  = mem_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!halted) begin
            if ((lstall || dmem_busy) && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
            if (br_act && (flush_cnt_q != 16'hFFFF))                flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with default parameters.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_rs_used, id_rt_used, id_wr, id_is_load, id_is_hlt;
    logic [3:0] id_rs, id_rt, id_rd;
    logic       br_taken, imem_busy, dmem_busy;
    logic       pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze, hlt;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } sb_t;
    sb_t sb[$];

    // {pc_we, ifid_we}_{flush, bubble, freeze}_{fwd_a}_{fwd_b}_{hlt}
    localparam logic [9:0] E_RUN = 10'b11_000_00_00_0;
    localparam logic [9:0] E_LU  = 10'b00_010_00_00_0;
    localparam logic [9:0] E_IM  = 10'b01_100_00_00_0;
    localparam logic [9:0] E_DM  = 10'b00_001_00_00_0;
    localparam logic [9:0] E_BR  = 10'b11_110_00_00_0;
    localparam logic [9:0] E_HLT = 10'b00_000_00_00_1;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rd(id_rd), .id_wr(id_wr), .id_is_load(id_is_load), .id_is_hlt(id_is_hlt),
        .br_taken(br_taken), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .hlt(hlt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got[9:0], exp[9:0]);
    endtask

    // fl = {rs_used, rt_used, wr, load, is_hlt}, ctl = {br_taken, imem_busy, dmem_busy}
    task automatic row(input string tag, input bit en, input logic rst, input logic v,
                       input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                       input logic [4:0] fl, input logic [2:0] ctl, input logic [9:0] exp);
        sb_t e;
        @(posedge clk);
        #1;
        rst_n      = rst;
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        {id_rs_used, id_rt_used, id_wr, id_is_load, id_is_hlt} = fl;
        {br_taken, imem_busy, dmem_busy} = ctl;
        if (en) begin
            e.tag = tag;
            e.exp = exp;
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t e;
            e = sb.pop_front();
            chk(e.tag, 32'({pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze,
                            fwd_a_sel, fwd_b_sel, hlt}), 32'(e.exp));
        end
    end

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
        id_rs_used = 1'b0; id_rt_used = 1'b0; id_wr = 1'b0; id_is_load = 1'b0; id_is_hlt = 1'b0;
        br_taken = 1'b0; imem_busy = 1'b0; dmem_busy = 1'b0;

        row("rst",            0, 0, 0,  0, 0,  0, 5'b00000, 3'b000, E_RUN);
        row("rst",            0, 0, 0,  0, 0,  0, 5'b00000, 3'b000, E_RUN);
        row("reset state",    1, 1, 0,  0, 0,  0, 5'b00000, 3'b000, E_RUN);
        // forwarding: ADD r3, then consumers
        row("add r3",         1, 1, 1,  1, 2,  3, 5'b11100, 3'b000, E_RUN);
        row("sub r4 rd r3",   1, 1, 1,  3, 6,  4, 5'b11100, 3'b000, E_RUN);
        row("fwd a mem",      1, 1, 1,  5, 3,  7, 5'b11100, 3'b000, 10'b11_000_01_00_0);
        row("fwd b wb",       1, 1, 0,  0, 0,  0, 5'b00000, 3'b000, 10'b11_000_00_10_0);
        row("wr r8 a",        1, 1, 1,  2, 2,  8, 5'b11100, 3'b000, E_RUN);
        row("wr r8 b",        1, 1, 1,  1, 1,  8, 5'b11100, 3'b000, E_RUN);
        row("rd r8",          1, 1, 1,  9, 8, 10, 5'b11100, 3'b000, E_RUN);
        row("fwd mem over wb",1, 1, 0,  0, 0,  0, 5'b00000, 3'b000, 10'b11_000_00_01_0);
        // register zero
        row("wr r0 a",        1, 1, 1,  1, 1,  0, 5'b11100, 3'b000, E_RUN);
        row("wr r0 b",        1, 1, 1,  1, 1,  0, 5'b11100, 3'b000, E_RUN);
        row("rd r0",          1, 1, 1,  0, 0,  0, 5'b11000, 3'b000, E_RUN);
        row("r0 no fwd",      1, 1, 0,  0, 0,  0, 5'b00000, 3'b000, E_RUN);
        row("lw r0",          1, 1, 1,  1, 0,  0, 5'b10110, 3'b000, E_RUN);
        row("r0 no stall",    1, 1, 1,  0, 0, 11, 5'b11100, 3'b000, E_RUN);
        row("nop",            1, 1, 0,  0, 0,  0, 5'b00000, 3'b000, E_RUN);
        // load-use
        row("lw r5",          1, 1, 1,  1, 0,  5, 5'b10110, 3'b000, E_RUN);
        row("load-use rs",    1, 1, 1,  5, 2,  6, 5'b11100, 3'b000, E_LU);
        row("post stall",     1, 1, 1,  5, 2,  6, 5'b11100, 3'b000, E_RUN);
        row("load fwd wb",    1, 1, 0,  0, 0,  0, 5'b00000, 3'b000, 10'b11_000_10_00_0);
        row("lw r7",          1, 1, 1,  2, 0,  7, 5'b10110, 3'b000, E_RUN);
        row("unused rt",      1, 1, 1,  1, 7, 13, 5'b10100, 3'b000, E_RUN);
        row("lw r9",          1, 1, 1,  3, 0,  9, 5'b10110, 3'b000, E_RUN);
        row("load-use rt",    1, 1, 1,  0, 9, 12, 5'b01100, 3'b000, E_LU);
        row("post stall rt",  1, 1, 1,  0, 9, 12, 5'b01100, 3'b000, E_RUN);
        row("lw r4 fwd b wb", 1, 1, 1,  1, 0,  4, 5'b10110, 3'b000, 10'b11_000_00_10_0);
        // branch beats a pending load-use
        row("br over lu",     1, 1, 1,  4, 0, 14, 5'b10100, 3'b100, E_BR);
        row("br back to run", 1, 1, 0,  0, 0,  0, 5'b00000, 3'b000, E_RUN);
        // fetch and data stalls
        row("imem busy",      1, 1, 1,  1, 0,  2, 5'b10100, 3'b010, E_IM);
        row("rd r2",          1, 1, 1,  2, 0,  3, 5'b10100, 3'b000, E_RUN);
        row("dmem freeze",    1, 1, 0,  0, 0,  0, 5'b00000, 3'b001, 10'b00_001_01_00_0);
        row("dmem over br",   1, 1, 0,  0, 0,  0, 5'b00000, 3'b101, 10'b00_001_01_00_0);
        row("freeze held",    1, 1, 0,  0, 0,  0, 5'b00000, 3'b000, 10'b11_000_01_00_0);
        row("nop",            1, 1, 0,  0, 0,  0, 5'b00000, 3'b000, E_RUN);
        // HLT drain with two data stalls inside
        row("hlt in id",      0, 1, 1,  0, 0,  0, 5'b00001, 3'b000, E_RUN);
        row("drain 1",        1, 1, 0,  0, 0,  0, 5'b00000, 3'b000, E_IM);
        row("drain dmem 1",   1, 1, 0,  0, 0,  0, 5'b00000, 3'b001, E_DM);
        row("drain dmem 2",   1, 1, 0,  0, 0,  0, 5'b00000, 3'b001, E_DM);
        row("drain 2",        1, 1, 0,  0, 0,  0, 5'b00000, 3'b000, E_IM);
        row("drain 3",        1, 1, 0,  0, 0,  0, 5'b00000, 3'b000, E_IM);
        row("halted",         1, 1, 0,  0, 0,  0, 5'b00000, 3'b000, E_HLT);
        row("hlt sticky br",  1, 1, 0,  0, 0,  0, 5'b00000, 3'b100, E_HLT);
        row("hlt sticky id",  1, 1, 1,  1, 2,  3, 5'b11100, 3'b010, E_HLT);
        row("rst in halted",  0, 0, 0,  0, 0,  0, 5'b00000, 3'b000, E_RUN);
        row("reset from hlt", 1, 1, 0,  0, 0,  0, 5'b00000, 3'b000, E_RUN);
        // branch cancels a drain
        row("hlt again",      0, 1, 1,  0, 0,  0, 5'b00001, 3'b000, E_RUN);
        row("drain again",    1, 1, 0,  0, 0,  0, 5'b00000, 3'b000, E_IM);
        row("br in drain",    1, 1, 0,  0, 0,  0, 5'b00000, 3'b100, E_BR);
        for (int i = 0; i < 4; i++)
            row("drain cancelled", 1, 1, 0, 0, 0, 0, 5'b00000, 3'b000, E_RUN);

        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        chk("sb drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
